div_iter_param: RTL
===================

Name: div_iter_param

Overview:
- Parametrised multi-cycle restoring divider; next generation of the execute-stage HI/LO divide unit.
- Generalised in operand width and radix: retires 1 or 2 quotient bits per cycle.
- Adds an explicit divide-by-zero flag, a busy indication and a defined result for most-negative / -1.
- Sits beside the ALU in EX; the pipeline stalls on busy_o and writes HI/LO when ready_o is high.

Parameters:
- WIDTH, 32, operand width in bits; even, >= 4.
- BITS_PER_CYCLE, 1, quotient bits retired per iteration cycle; legal values 1 or 2; WIDTH must be divisible by it.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; level-sensitive, held by the pipeline until the result is consumed
- annul_i  in  1  cancel (exception/flush)
- result_o  out  2*WIDTH  {remainder, quotient}; remainder in [2W-1:W], quotient in [W-1:0]
- ready_o  out  1  result_o valid
- dbz_o  out  1  last completed operation had divisor 0; valid while ready_o is high
- busy_o  out  1  state is not IDLE

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk.
  - All outputs reset to 0 (result_o=0, ready_o=0, dbz_o=0, busy_o=0).
  - State goes to IDLE; the iteration counter goes to 0.
  - Reset wins over every other input, including reset asserted mid-operation.
- States: IDLE, CALC, FIX, DONE. busy_o = (state != IDLE), combinational from the state register.
- IDLE:
  - Leaves IDLE only when start_i=1 and annul_i=0; the operands and signed_div_i are latched at that edge.
  - If opdata2_i==0: go to DONE. result_o = {opdata1_i, all-ones quotient}, dbz_o=1, ready_o=1 from the next cycle (1-cycle latency).
  - Otherwise go to CALC:
    - Latch the operand magnitudes; negate when signed and MSB=1.
    - Latch the sign bits.
    - Clear the partial remainder; set count=0.
  - While in IDLE, ready_o, dbz_o and result_o are held at 0.
- CALC: one iteration per cycle, K = WIDTH/BITS_PER_CYCLE cycles.
  - Each iteration shifts BITS_PER_CYCLE dividend bits into the partial remainder.
  - For each bit, trial-subtract the divisor using a (WIDTH+1)-bit subtract and restore on borrow.
  - The quotient bit is set when there is no borrow.
  - When BITS_PER_CYCLE=2, the two subtract stages are chained combinationally within one cycle.
  - After K iterations go to FIX.
  - annul_i=1 in CALC: go to IDLE at that edge, no ready_o, no result update.
- FIX: one cycle, then DONE with ready_o=1 and dbz_o=0.
  - Signed mode: quotient is negated if the latched signs differ; remainder is negated if the dividend sign is 1. The remainder therefore takes the dividend's sign.
  - Unsigned mode: pass-through.
  - annul_i in FIX is ignored.
- Latency: with accept edge e0, ready_o is first high after edge e(K+1).
  - WIDTH=32, BPC=1: 34 cycles.
  - WIDTH=32, BPC=2: 18 cycles.
- DONE:
  - result_o, ready_o and dbz_o are held stable while start_i=1; annul_i is ignored.
  - When start_i=0 at an edge: go to IDLE and clear result_o, ready_o and dbz_o at that same edge.
  - Start held high never re-triggers; a new divide requires start_i low for at least one edge.
- Overflow (signed most-negative / -1): quotient wraps to most-negative (0x80000000 for W=32), remainder 0. No flag.
- Inputs are sampled only in IDLE; operand changes during CALC/FIX/DONE have no effect.

Test Plan:
- W=32, BPC=1, unsigned 7/2, start held high -> ready_o after 34 cycles; result_o = {0x00000001, 0x00000003}; dbz_o=0; outputs clear one edge after start_i drops.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Divide by zero 0x12345678 / 0 -> ready_o next cycle; result_o = {0x12345678, 0xFFFFFFFF}; dbz_o=1; busy_o high for exactly that one cycle.
- annul_i pulsed at CALC iteration 10 -> state IDLE; ready_o never asserts; a following 100/7 gives q=14, r=2 with full latency. resetn pulsed mid-CALC -> all outputs 0 on the next edge.
- BPC=2, W=16, randomized signed/unsigned operands against a reference model -> results match; latency 10 cycles; start_i held high after DONE does not restart the divide.

Source files
------------

// File: rtl/div_iter_param_if.sv
// div_iter_param_if: request/result bundle between the EX pipeline and the iterative divider
interface div_iter_param_if #(
   parameter int WIDTH = 32
);
   logic                 signed_div_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic                 start_i;
   logic                 annul_i;
   logic [2*WIDTH-1:0]   result_o;
   logic                 ready_o;
   logic                 dbz_o;
   logic                 busy_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, dbz_o, busy_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, dbz_o, busy_o
   );
endinterface

// File: rtl/div_iter_param.sv
// div_iter_param: multi-cycle restoring divider retiring BITS_PER_CYCLE quotient bits per cycle
module div_iter_param #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic              clk,
   input logic              resetn,
   div_iter_param_if.slave  bus
);
   localparam int K  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(K + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               state, state_n;
   logic [WIDTH-1:0]     dq, dvs, rem, q_n, r_n, mag1, mag2;
   logic [WIDTH:0]       t, d;
   logic                 borrow, sq, sr, accept, zero_div;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   result;
   logic                 ready, dbz;

   assign accept   = bus.start_i & ~bus.annul_i;
   assign zero_div = bus.opdata2_i == '0;
   assign mag1     = (bus.signed_div_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
   assign mag2     = (bus.signed_div_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

   assign bus.result_o = result;
   assign bus.ready_o  = ready;
   assign bus.dbz_o    = dbz;
   assign bus.busy_o   = state != IDLE;

   // Chained restoring steps; dq holds the dividend bits not yet consumed and collects quotient bits at the bottom
   always_comb begin
      r_n    = rem;
      q_n    = dq;
      t      = '0;
      d      = '0;
      borrow = 1'b0;
      for (int b = 0; b < BITS_PER_CYCLE; b++) begin
         t           = {r_n, q_n[WIDTH-1]};
         {borrow, d} = {1'b0, t} - {2'b0, dvs};
         r_n         = WIDTH'(borrow ? t : d);
         q_n         = {q_n[WIDTH-2:0], ~borrow};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   // Next-state: zero divisor short-cuts to DONE, annul only aborts CALC, DONE waits for start to drop
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? (zero_div ? DONE : CALC) : IDLE;
         CALC:    state_n = bus.annul_i ? IDLE : (count == CW'(K - 1) ? FIX : CALC);
         FIX:     state_n = DONE;
         DONE:    state_n = bus.start_i ? DONE : IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, sign fix-up and result hold/clear
   always_ff @(posedge clk) begin
      if (!resetn) begin
         dq     <= '0;
         dvs    <= '0;
         rem    <= '0;
         count  <= '0;
         sq     <= 1'b0;
         sr     <= 1'b0;
         result <= '0;
         ready  <= 1'b0;
         dbz    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               result <= '0;
               ready  <= 1'b0;
               dbz    <= 1'b0;
               if (accept && zero_div) begin
                  result <= {bus.opdata1_i, {WIDTH{1'b1}}};
                  ready  <= 1'b1;
                  dbz    <= 1'b1;
               end else if (accept) begin
                  dq    <= mag1;
                  dvs   <= mag2;
                  rem   <= '0;
                  count <= '0;
                  sq    <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                  sr    <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
               end
            end
            CALC: begin
               dq    <= q_n;
               rem   <= r_n;
               count <= count + CW'(1);
            end
            FIX: begin
               result <= {sr ? -rem : rem, sq ? -dq : dq};
               ready  <= 1'b1;
               dbz    <= 1'b0;
            end
            DONE: begin
               if (!bus.start_i) begin
                  result <= '0;
                  ready  <= 1'b0;
                  dbz    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
